limb_calc: RTL and testbench

Parametrised multi-limb calculator core: the next-generation successor to the keypad calculator's two-cycle 16-bit datapath. It executes a W-bit ADD, SUB, AND, OR, signed LESS-THAN or EQUAL one L-bit limb per clock, using an internal L-bit limb ALU. It holds the previous answer for chained operations and raises a done pulse that the top level uses to trigger display refresh and the buzzer. It sits between the keypad decoder (operands, op code, start) and the 7-segment/LED/music outputs.

---
 rtl/limb_calc.sv | 202 ++++++++++++++++++++
 tb/tb_limb_calc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/limb_calc.sv
// Multi-limb calculator core: executes a W-bit ADD/SUB/AND/OR/LT/EQ one L-bit limb per clock.
// Holds the last committed answer so that operand A can be chained from it.
module limb_calc #(
  parameter int W = 16,
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         a_is_ans,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         abort,
  output logic         ready,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         less
);

  localparam int N  = W / L;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_LT  = 3'd4;
  localparam logic [2:0] OP_EQ  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_ASC, S_DESC} state_t;

  // Returns {carry_out, limb}; SUB relies on the caller seeding cin=1 on limb 0.
  function automatic logic [L:0] limb_alu(input logic [2:0] opc, input logic [L-1:0] x,
                                          input logic [L-1:0] y, input logic cin);
    case (opc)
      OP_ADD:  return {1'b0, x} + {1'b0, y} + (L+1)'(cin);
      OP_SUB:  return {1'b0, x} + {1'b0, ~y} + (L+1)'(cin);
      OP_AND:  return {1'b0, x & y};
      OP_OR:   return {1'b0, x | y};
      default: return '0;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   opa_q, opa_d, opb_q, opb_d, work_q, work_d;
  logic [2:0]     op_q, op_d;
  logic           cy_q, cy_d, nz_q, nz_d;
  logic [W-1:0]   result_q, result_d;
  logic           zero_q, zero_d, carry_q, carry_d, less_q, less_d;
  logic           done_q, done_d, err_q, err_d;

  logic [31:0]    sh;
  logic [L-1:0]   la, lb;
  logic [L:0]     alu;
  logic [W-1:0]   limb_mask, work_nx;
  logic           nz_nx, hit, flag;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    cy_d     = cy_q;
    work_d   = work_q;
    nz_d     = nz_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    less_d   = less_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    hit      = 1'b0;
    flag     = 1'b0;

    sh        = 32'(idx_q) * 32'(L);
    la        = L'(opa_q >> sh);
    lb        = L'(opb_q >> sh);
    alu       = limb_alu(op_q, la, lb, cy_q);
    limb_mask = W'({L{1'b1}}) << sh;
    work_nx   = (work_q & ~limb_mask) | (W'(alu[L-1:0]) << sh);
    nz_nx     = nz_q | (|alu[L-1:0]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op > OP_EQ) begin
            err_d = 1'b1;
          end else begin
            opa_d  = a_is_ans ? result_q : a;
            opb_d  = b;
            op_d   = op;
            cy_d   = (op == OP_SUB);
            work_d = '0;
            nz_d   = 1'b0;
            if (op == OP_LT || op == OP_EQ) begin
              state_d = S_DESC;
              idx_d   = LAST;
            end else begin
              state_d = S_ASC;
              idx_d   = '0;
            end
          end
        end
      end
      S_ASC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          work_d = work_nx;
          nz_d   = nz_nx;
          cy_d   = alu[L];
          if (idx_q == LAST) begin
            result_d = work_nx;
            zero_d   = ~nz_nx;
            carry_d  = (op_q == OP_ADD) ? alu[L] : ((op_q == OP_SUB) ? ~alu[L] : 1'b0);
            less_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DESC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // Top-limb sign mismatch decides a signed LT without looking further.
          if (op_q == OP_LT && idx_q == LAST && la[L-1] != lb[L-1]) begin
            hit  = 1'b1;
            flag = la[L-1];
          end else if (la != lb) begin
            hit  = 1'b1;
            flag = (op_q == OP_LT) && (la < lb);
          end else if (idx_q == '0) begin
            hit  = 1'b1;
            flag = (op_q == OP_EQ);
          end
          if (hit) begin
            result_d = W'(flag);
            zero_d   = ~flag;
            carry_d  = 1'b0;
            less_d   = (op_q == OP_LT) && flag;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      less_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      less_q   <= less_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Operand and working registers carry no reset; they are rewritten on every accepted start.
  always_ff @(posedge clk) begin
    opa_q  <= opa_d;
    opb_q  <= opb_d;
    op_q   <= op_d;
    cy_q   <= cy_d;
    work_q <= work_d;
    nz_q   <= nz_d;
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign less   = less_q;

endmodule

// File: tb/tb_limb_calc.sv
// Scoreboard bench for limb_calc: a 16-bit/8-bit instance and a 32-bit/8-bit instance,
// directed vectors with hand-computed answers and commit latencies.
module tb_limb_calc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n16, start16, ans16, abort16, ready16, done16, err16, zero16, carry16, less16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, result16;

  logic        rst_n32, start32, ans32, abort32, ready32, done32, err32, zero32, carry32, less32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, result32;

  limb_calc #(.W(16), .L(8)) u16 (
    .clk(clk), .rst_n(rst_n16), .start(start16), .op(op16), .a_is_ans(ans16),
    .a(a16), .b(b16), .abort(abort16), .ready(ready16), .done(done16), .err(err16),
    .result(result16), .zero(zero16), .carry(carry16), .less(less16)
  );

  limb_calc #(.W(32), .L(8)) u32 (
    .clk(clk), .rst_n(rst_n32), .start(start32), .op(op32), .a_is_ans(ans32),
    .a(a32), .b(b32), .abort(abort32), .ready(ready32), .done(done32), .err(err32),
    .result(result32), .zero(zero32), .carry(carry32), .less(less32)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        l;
    int          t0;
    int          lat;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endfunction

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        chk("unexpected_done16", 32'(q16.size()), 1);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("res16", 32'(result16), e.res);
        chk("zero16", 32'(zero16), 32'(e.z));
        chk("carry16", 32'(carry16), 32'(e.c));
        chk("less16", 32'(less16), 32'(e.l));
        chk("lat16", 32'(cyc - e.t0), 32'(e.lat));
        chk("ready_at_done16", 32'(ready16), 1);
      end
    end
  end

  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", 32'(q32.size()), 1);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("res32", result32, e.res);
        chk("zero32", 32'(zero32), 32'(e.z));
        chk("carry32", 32'(carry32), 32'(e.c));
        chk("less32", 32'(less32), 32'(e.l));
        chk("lat32", 32'(cyc - e.t0), 32'(e.lat));
        chk("ready_at_done32", 32'(ready32), 1);
      end
    end
  end

  task automatic run16(input logic [2:0] o, input logic ans, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] er, input logic ez, input logic ec, input logic el, input int lat);
    exp_t e;
    bit seen;
    e.res = 32'(er); e.z = ez; e.c = ec; e.l = el; e.t0 = cyc + 1; e.lat = lat;
    q16.push_back(e);
    op16 = o; ans16 = ans; a16 = x; b16 = y; start16 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (done16 === 1'b1) seen = 1'b1;
    end
    chk("done16_wait", 32'(done16), 1);
  endtask

  task automatic run32(input logic [2:0] o, input logic ans, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic ez, input logic ec, input logic el, input int lat);
    exp_t e;
    bit seen;
    e.res = er; e.z = ez; e.c = ec; e.l = el; e.t0 = cyc + 1; e.lat = lat;
    q32.push_back(e);
    op32 = o; ans32 = ans; a32 = x; b32 = y; start32 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      start32 = 1'b0;
      if (done32 === 1'b1) seen = 1'b1;
    end
    chk("done32_wait", 32'(done32), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n16 = 1'b0; start16 = 1'b0; op16 = '0; ans16 = 1'b0; a16 = '0; b16 = '0; abort16 = 1'b0;
    rst_n32 = 1'b0; start32 = 1'b0; op32 = '0; ans32 = 1'b0; a32 = '0; b32 = '0; abort32 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready16", 32'(ready16), 1);
    chk("rst_done16", 32'(done16), 0);
    chk("rst_err16", 32'(err16), 0);
    chk("rst_result16", 32'(result16), 0);
    chk("rst_flags16", {29'd0, zero16, carry16, less16}, 0);
    chk("rst_result32", result32, 0);
    chk("rst_ready32", 32'(ready32), 1);
    rst_n16 = 1'b1; rst_n32 = 1'b1;
    @(negedge clk);

    // 16-bit vectors: op, a_is_ans, a, b, result, zero, carry, less, latency
    run16(3'd0, 0, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0, 2);
    run16(3'd1, 0, 16'h0005, 16'h0007, 16'hFFFE, 0, 1, 0, 2);
    run16(3'd1, 1, 16'h0000, 16'hFFFE, 16'h0000, 1, 0, 0, 2);
    run16(3'd1, 0, 16'h0007, 16'h0005, 16'h0002, 0, 0, 0, 2);
    run16(3'd0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 2);
    run16(3'd2, 0, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 2);
    run16(3'd3, 0, 16'h0F00, 16'h00F0, 16'h0FF0, 0, 0, 0, 2);
    run16(3'd4, 0, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0, 2);
    run16(3'd4, 0, 16'h1280, 16'h1201, 16'h0000, 1, 0, 0, 2);
    run16(3'd4, 0, 16'hFFFE, 16'hFFFF, 16'h0001, 0, 0, 1, 2);
    run16(3'd5, 0, 16'h12AB, 16'h13AB, 16'h0000, 1, 0, 0, 1);
    run16(3'd5, 0, 16'hABCD, 16'hABCD, 16'h0001, 0, 0, 0, 2);
    run16(3'd4, 0, 16'h8000, 16'h0001, 16'h0001, 0, 0, 1, 1);

    // Abort the cycle after acceptance: no commit, answer keeps 1.
    op16 = 3'd0; ans16 = 1'b0; a16 = 16'h1111; b16 = 16'h2222; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; abort16 = 1'b1;
    chk("busy_ready16", 32'(ready16), 0);
    @(negedge clk);
    abort16 = 1'b0;
    chk("abort_ready16", 32'(ready16), 1);
    chk("abort_done16", 32'(done16), 0);
    chk("abort_result16", 32'(result16), 1);
    @(negedge clk);
    chk("abort_late_done16", 32'(done16), 0);
    chk("abort_late_result16", 32'(result16), 1);

    // Invalid op: err pulse only.
    op16 = 3'd7; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    chk("err_pulse16", 32'(err16), 1);
    chk("err_ready16", 32'(ready16), 1);
    chk("err_done16", 32'(done16), 0);
    chk("err_result16", 32'(result16), 1);
    chk("err_less16", 32'(less16), 1);
    @(negedge clk);
    chk("err_clear16", 32'(err16), 0);
    run16(3'd0, 1, 16'h0000, 16'h0002, 16'h0003, 0, 0, 0, 2);

    // 32-bit vectors
    run32(3'd5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000001, 0, 0, 0, 4);
    run32(3'd1, 0, 32'h00000100, 32'h00000001, 32'h000000FF, 0, 0, 0, 4);
    run32(3'd0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 4);

    // Reset in the middle of an ADD.
    op32 = 3'd0; ans32 = 1'b0; a32 = 32'h12345678; b32 = 32'h11111111; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    rst_n32 = 1'b0;
    @(negedge clk);
    rst_n32 = 1'b1;
    chk("mid_rst_result32", result32, 0);
    chk("mid_rst_zero32", 32'(zero32), 0);
    chk("mid_rst_carry32", 32'(carry32), 0);
    chk("mid_rst_less32", 32'(less32), 0);
    chk("mid_rst_ready32", 32'(ready32), 1);
    chk("mid_rst_done32", 32'(done32), 0);
    chk("mid_rst_err32", 32'(err32), 0);
    @(negedge clk);
    run32(3'd0, 0, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 0, 4);
    run32(3'd4, 0, 32'h80000000, 32'h00000001, 32'h00000001, 0, 0, 1, 1);
    run32(3'd4, 0, 32'h00010000, 32'h00010001, 32'h00000001, 0, 0, 1, 4);

    repeat (3) @(negedge clk);
    chk("q16_drained", 32'(q16.size()), 0);
    chk("q32_drained", 32'(q32.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
